// File: rtl/mci_pkg.sv
// Shared MCI definitions: boot FSM state encoding and hitless-update reset hold length.
package mci_pkg;

    localparam int unsigned MCI_MCU_UPDATE_RESET_CYLES = 10;
    localparam int unsigned MCI_BOOT_STATE_W           = 4;

    typedef enum logic [MCI_BOOT_STATE_W-1:0] {
        BOOT_IDLE        = 4'h0,
        BOOT_OTP_FC      = 4'h1,
        BOOT_LCC         = 4'h2,
        BOOT_MCU         = 4'h3,
        BOOT_WAIT_UPDATE = 4'h4,
        BOOT_RST_MCU     = 4'h5
    } mci_boot_fsm_state_e;

endpackage

// File: rtl/mci_boot_seqr_if.sv
// Boot sequencer control bundle: breakpoint, init handshakes, update request and reset outputs.
interface mci_boot_seqr_if;
    import mci_pkg::*;

    logic                brkpoint_en_i;
    logic                brkpoint_go_i;
    logic                fc_done_i;
    logic                lcc_done_i;
    logic                fw_update_req_i;
    logic                fc_init_o;
    logic                lcc_init_o;
    logic                cptra_rst_b_o;
    logic                mcu_rst_b_o;
    logic                update_done_o;
    mci_boot_fsm_state_e boot_fsm_state_o;

    // Sequencer side
    modport master (
        input  brkpoint_en_i,
        input  brkpoint_go_i,
        input  fc_done_i,
        input  lcc_done_i,
        input  fw_update_req_i,
        output fc_init_o,
        output lcc_init_o,
        output cptra_rst_b_o,
        output mcu_rst_b_o,
        output update_done_o,
        output boot_fsm_state_o
    );

    // SoC / environment side
    modport slave (
        output brkpoint_en_i,
        output brkpoint_go_i,
        output fc_done_i,
        output lcc_done_i,
        output fw_update_req_i,
        input  fc_init_o,
        input  lcc_init_o,
        input  cptra_rst_b_o,
        input  mcu_rst_b_o,
        input  update_done_o,
        input  boot_fsm_state_o
    );

endinterface

// File: rtl/mci_boot_seqr.sv
// MCI boot sequencer: fuse ctrl -> lifecycle ctrl -> Caliptra/MCU release, plus hitless MCU reset.
// Breakpoint hold in BOOT_IDLE is enabled by defining MCI_BOOT_BRKPOINT_EN.
module mci_boot_seqr
    import mci_pkg::*;
#(
    parameter int unsigned UPDATE_RST_CYCLES = MCI_MCU_UPDATE_RESET_CYLES
) (
    input  logic           clk,
    input  logic           mci_rst_b,
    mci_boot_seqr_if.master bus
);

    localparam int unsigned       CNT_W    = $clog2(UPDATE_RST_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(UPDATE_RST_CYCLES - 1);

    mci_boot_fsm_state_e state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                update_q, update_d;

    // State, reset-hold counter and update-complete flag
    always_ff @(posedge clk or negedge mci_rst_b) begin
        if (!mci_rst_b) begin
            state_q  <= BOOT_IDLE;
            cnt_q    <= '0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            update_q <= update_d;
        end
    end

`ifndef MCI_BOOT_BRKPOINT_EN
    logic unused_brkpoint;
    assign unused_brkpoint = bus.brkpoint_en_i ^ bus.brkpoint_go_i;
`endif

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        update_d = 1'b0;
        case (state_q)
            BOOT_IDLE: begin
`ifdef MCI_BOOT_BRKPOINT_EN
                if (!bus.brkpoint_en_i || bus.brkpoint_go_i) begin
                    state_d = BOOT_OTP_FC;
                end
`else
                state_d = BOOT_OTP_FC;
`endif
            end
            BOOT_OTP_FC: begin
                if (bus.fc_done_i) begin
                    state_d = BOOT_LCC;
                end
            end
            BOOT_LCC: begin
                if (bus.lcc_done_i) begin
                    state_d = BOOT_MCU;
                end
            end
            BOOT_MCU: begin
                state_d = BOOT_WAIT_UPDATE;
            end
            BOOT_WAIT_UPDATE: begin
                if (bus.fw_update_req_i) begin
                    state_d = BOOT_RST_MCU;
                    cnt_d   = '0;
                end
            end
            BOOT_RST_MCU: begin
                // Requests seen here are dropped; only the hold count matters.
                if (cnt_q == CNT_LAST) begin
                    state_d  = BOOT_MCU;
                    update_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = BOOT_IDLE;
            end
        endcase
    end

    // Moore output decode from the registered state; illegal encodings decode as idle
    always_comb begin
        bus.fc_init_o     = 1'b0;
        bus.lcc_init_o    = 1'b0;
        bus.cptra_rst_b_o = 1'b0;
        bus.mcu_rst_b_o   = 1'b0;
        case (state_q)
            BOOT_OTP_FC: begin
                bus.fc_init_o = 1'b1;
            end
            BOOT_LCC: begin
                bus.fc_init_o  = 1'b1;
                bus.lcc_init_o = 1'b1;
            end
            BOOT_MCU, BOOT_WAIT_UPDATE: begin
                bus.fc_init_o     = 1'b1;
                bus.lcc_init_o    = 1'b1;
                bus.cptra_rst_b_o = 1'b1;
                bus.mcu_rst_b_o   = 1'b1;
            end
            BOOT_RST_MCU: begin
                bus.fc_init_o     = 1'b1;
                bus.lcc_init_o    = 1'b1;
                bus.cptra_rst_b_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.update_done_o    = update_q;
    assign bus.boot_fsm_state_o = state_q;

endmodule

// File: tb/tb_mci_boot_seqr.sv
// Scoreboard bench for mci_boot_seqr: per-cycle expected output vectors queued by stimulus, checked by a monitor.
module tb_mci_boot_seqr;
    import mci_pkg::*;

    logic clk = 1'b0;
    logic mci_rst_b;

    always #5 clk = ~clk;

    mci_boot_seqr_if bus ();

    mci_boot_seqr #(.UPDATE_RST_CYCLES(10)) dut (
        .clk       (clk),
        .mci_rst_b (mci_rst_b),
        .bus       (bus)
    );

    typedef struct {
        string      tag;
        logic [8:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Expected {state, fc_init, lcc_init, cptra_rst_b, mcu_rst_b, update_done}
    function automatic logic [8:0] expect_vec(input logic [3:0] st, input logic done);
        logic [3:0] o;
        case (st)
            4'h0:    o = 4'b0000;
            4'h1:    o = 4'b1000;
            4'h2:    o = 4'b1100;
            4'h3:    o = 4'b1111;
            4'h4:    o = 4'b1111;
            4'h5:    o = 4'b1110;
            default: o = 4'b0000;
        endcase
        return {st, o, done};
    endfunction

    task automatic check_vec(input string tag, input logic [8:0] want);
        logic [8:0] act;
        act = {4'(bus.boot_fsm_state_o), bus.fc_init_o, bus.lcc_init_o,
               bus.cptra_rst_b_o, bus.mcu_rst_b_o, bus.update_done_o};
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got state=%0h fc/lcc/cptra/mcu/done=%b, want state=%0h fc/lcc/cptra/mcu/done=%b",
                     tag, act[8:5], act[4:0], want[8:5], want[4:0]);
        end
    endtask

    task automatic drive(input logic bke, input logic bkg, input logic fc,
                         input logic lcc, input logic fw);
        bus.brkpoint_en_i   = bke;
        bus.brkpoint_go_i   = bkg;
        bus.fc_done_i       = fc;
        bus.lcc_done_i      = lcc;
        bus.fw_update_req_i = fw;
    endtask

    // One cycle: the DUT should sit in st now; inputs apply to the edge that ends this cycle
    task automatic cyc(input string tag, input mci_boot_fsm_state_e st, input logic done,
                       input logic bke, input logic bkg, input logic fc,
                       input logic lcc, input logic fw);
        exp_t e;
        e.tag = tag;
        e.vec = expect_vec(4'(st), done);
        exp_q.push_back(e);
        @(negedge clk);
        drive(bke, bkg, fc, lcc, fw);
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; asserts reset mid-cycle and releases it after a rising edge
    task automatic apply_reset(input string tag, input logic fc);
        mci_rst_b = 1'b0;
        #1;
        check_vec({tag, "_async"}, 9'h000);
        drive(1'b0, 1'b0, fc, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_vec({tag, "_held"}, 9'h000);
        mci_rst_b = 1'b1;
    endtask

    task automatic hitless_update(input string tag);
        cyc({tag, "_req"}, BOOT_WAIT_UPDATE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++)
            cyc({tag, "_rst"}, BOOT_RST_MCU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc({tag, "_mcu"}, BOOT_MCU, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++)
            cyc({tag, "_wait"}, BOOT_WAIT_UPDATE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare the DUT outputs against the oldest queued expectation each cycle
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check_vec(e.tag, e.vec);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mci_rst_b = 1'b1;
        @(posedge clk);
        #1;
        apply_reset("por", 1'b0);

        // Breakpoint hold (macro build) or ignored breakpoint (default build)
`ifdef MCI_BOOT_BRKPOINT_EN
        for (int i = 0; i < 19; i++)
            cyc("brk_hold", BOOT_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("brk_go", BOOT_IDLE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`else
        cyc("brk_ignored", BOOT_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // Cold boot: fc_done in the 5th OTP_FC cycle, lcc_done in the 3rd LCC cycle
        for (int i = 0; i < 4; i++)
            cyc("otp_wait", BOOT_OTP_FC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("otp_done", BOOT_OTP_FC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++)
            cyc("lcc_wait", BOOT_LCC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("lcc_done", BOOT_LCC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("mcu_boot", BOOT_MCU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc("wait_idle", BOOT_WAIT_UPDATE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Hitless update with requests in late RST_MCU and in MCU that must be dropped
        cyc("upd_req", BOOT_WAIT_UPDATE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++)
            cyc("upd_rst", BOOT_RST_MCU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, logic'(i >= 7));
        cyc("upd_mcu", BOOT_MCU, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            cyc("upd_dropped", BOOT_WAIT_UPDATE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Second update: counter must restart from zero
        hitless_update("upd2");

        // fc_done high from reset, update request during LCC only
        apply_reset("rst2", 1'b1);
        cyc("early_idle", BOOT_IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc("early_otp", BOOT_OTP_FC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++)
            cyc("lcc_fw", BOOT_LCC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc("lcc_done2", BOOT_LCC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("mcu2", BOOT_MCU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc("no_latch", BOOT_WAIT_UPDATE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the 4th RST_MCU cycle, then a full reboot and update
        cyc("abort_req", BOOT_WAIT_UPDATE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            cyc("abort_rst", BOOT_RST_MCU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_reset("mid_rst", 1'b0);
        cyc("reboot_idle", BOOT_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("reboot_otp", BOOT_OTP_FC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("reboot_lcc", BOOT_LCC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("reboot_mcu", BOOT_MCU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        hitless_update("upd3");

        // Illegal state encoding recovers to idle
        force dut.state_q = mci_boot_fsm_state_e'(4'b0111);
        #1;
        check_vec("illegal_decode", 9'b0111_00000);
        release dut.state_q;
        @(posedge clk);
        #1;
        cyc("illegal_recover", BOOT_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("illegal_reboot", BOOT_OTP_FC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mci_boot_seqr.md
MCI_BOOT_SEQR -- requirements
Module: mci_boot_seqr

Interface
REQ-001: The block SHALL have parameter UPDATE_RST_CYCLES, default mci_pkg::MCI_MCU_UPDATE_RESET_CYLES (10), giving the number of cycles MCU reset is held low during a hitless update; legal range is 1 to 255.
REQ-002: clk  input  1  the single block clock; all logic SHALL be in this domain.
REQ-003: mci_rst_b  input  1  asynchronous, active-low reset.
REQ-004: brkpoint_en_i  input  1  when high, the boot sequence SHALL hold in BOOT_IDLE.
REQ-005: brkpoint_go_i  input  1  releases the breakpoint hold.
REQ-006: fc_done_i  input  1  fuse controller initialisation complete.
REQ-007: lcc_done_i  input  1  lifecycle controller initialisation complete.
REQ-008: fw_update_req_i  input  1  hitless MCU firmware update request.
REQ-009: fc_init_o  output  1  fuse controller init request.
REQ-010: lcc_init_o  output  1  lifecycle controller init request.
REQ-011: cptra_rst_b_o  output  1  Caliptra core reset, active-low.
REQ-012: mcu_rst_b_o  output  1  MCU reset, active-low.
REQ-013: update_done_o  output  1  single-cycle pulse marking completion of a hitless update.
REQ-014: boot_fsm_state_o  output  4  current state, typed mci_boot_fsm_state_e.

Function
REQ-015: The FSM SHALL use mci_boot_fsm_state_e and SHALL reach only BOOT_IDLE, BOOT_OTP_FC, BOOT_LCC, BOOT_MCU, BOOT_WAIT_UPDATE and BOOT_RST_MCU; every other encoding SHALL go to BOOT_IDLE on the next cycle.
REQ-016: In BOOT_IDLE, the FSM SHALL move to BOOT_OTP_FC on the next edge if brkpoint_en_i=0, or if brkpoint_en_i=1 and brkpoint_go_i=1; otherwise it SHALL stay in BOOT_IDLE.
REQ-017: In BOOT_OTP_FC, the FSM SHALL move to BOOT_LCC on the edge where fc_done_i=1; fc_done_i SHALL be ignored in every other state.
REQ-018: In BOOT_LCC, the FSM SHALL move to BOOT_MCU on the edge where lcc_done_i=1; lcc_done_i SHALL be ignored in every other state.
REQ-019: BOOT_MCU SHALL last exactly one cycle and then go to BOOT_WAIT_UPDATE.
REQ-020: In BOOT_WAIT_UPDATE, the FSM SHALL move to BOOT_RST_MCU on the edge where fw_update_req_i=1; fw_update_req_i SHALL not be latched in any other state.
REQ-021: BOOT_RST_MCU SHALL last exactly UPDATE_RST_CYCLES cycles, counted by a $clog2(UPDATE_RST_CYCLES+1)-bit counter that clears on entry, and SHALL then go to BOOT_MCU.
REQ-022: Outputs SHALL be Moore outputs decoded from the registered state only, with no combinational path from input to output.
REQ-023: fc_init_o SHALL be 1 in every state except BOOT_IDLE.
REQ-024: lcc_init_o SHALL be 1 in BOOT_LCC, BOOT_MCU, BOOT_WAIT_UPDATE and BOOT_RST_MCU.
REQ-025: cptra_rst_b_o SHALL be 1 in BOOT_MCU, BOOT_WAIT_UPDATE and BOOT_RST_MCU.
REQ-026: mcu_rst_b_o SHALL be 1 only in BOOT_MCU and BOOT_WAIT_UPDATE.
REQ-027: update_done_o SHALL pulse for the one BOOT_MCU cycle entered from BOOT_RST_MCU, using a registered flag.
REQ-028: A new fw_update_req_i arriving in BOOT_RST_MCU or BOOT_MCU SHALL be dropped; back-to-back updates SHALL need the request asserted again in BOOT_WAIT_UPDATE.

Reset
REQ-029: While mci_rst_b=0, the block SHALL hold state=BOOT_IDLE, counter=0, update flag=0, and every output at 0 (boot_fsm_state_o=4'b0000).
REQ-030: Reset asserted in the middle of any operation, including BOOT_RST_MCU, SHALL abort it immediately and return all outputs to their reset values with no clock edge needed.

Configuration
REQ-031: With macro MCI_BOOT_BRKPOINT_EN defined, breakpoint behaviour SHALL follow REQ-016.
REQ-032: Without MCI_BOOT_BRKPOINT_EN, brkpoint_en_i and brkpoint_go_i SHALL be ignored, BOOT_IDLE SHALL always exit after one cycle, and the ports SHALL remain present.

Structure
REQ-033: mci_boot_fsm_state_e and MCI_MCU_UPDATE_RESET_CYLES SHALL stay in mci_pkg, with no new package types.
REQ-034: The block SHALL be a single module with no sub-modules; the reset-hold counter SHALL be inline.

Verification
REQ-035: Scenario: brkpoint_en_i=0, fc_done_i rises 5 cycles after OTP_FC is entered, lcc_done_i rises 3 cycles after LCC is entered -> states IDLE(1)->OTP_FC(5)->LCC(3)->MCU(1)->WAIT_UPDATE; cptra_rst_b_o and mcu_rst_b_o rise together in the MCU cycle.
REQ-036: Scenario: with the macro defined, brkpoint_en_i=1 for 20 cycles and then brkpoint_go_i pulsed -> the FSM stays in IDLE for 20 cycles with fc_init_o=0 and enters OTP_FC on the edge after go; without the macro, OTP_FC is entered on cycle 2.
REQ-037: Scenario: fw_update_req_i pulsed for 1 cycle in WAIT_UPDATE, UPDATE_RST_CYCLES=10 -> mcu_rst_b_o is low for exactly 10 cycles, cptra_rst_b_o stays 1, and update_done_o pulses once in the following MCU cycle.
REQ-038: Scenario: fc_done_i=1 from reset onward and fw_update_req_i=1 during LCC -> OTP_FC lasts 1 cycle and no BOOT_RST_MCU occurs.
REQ-039: Scenario: mci_rst_b driven low in the 4th BOOT_RST_MCU cycle and then released -> all outputs are 0 asynchronously and the full boot restarts from BOOT_IDLE.
REQ-040: Scenario: state register forced to 4'b0111 -> BOOT_IDLE on the next cycle, with outputs matching the IDLE decode.
